// File: rtl/det_matrix_loader_pkg.sv
// Shared constants and state encoding for the determinant-core matrix loader.
// The one-hot state vector and matrix geometry are fixed by the det core.
package det_matrix_loader_pkg;

   localparam int N_ENTRIES = 64;
   localparam int ENTRY_W   = 4;
   localparam int DET_W     = 32;
   localparam int FLAT_W    = N_ENTRIES * ENTRY_W;
   localparam int LOAD_W    = 7;
   localparam int IDX_W     = 6;

   localparam logic [LOAD_W-1:0] LAST_IDX = LOAD_W'(N_ENTRIES - 1);

   typedef enum logic [5:0] {
      COLLECT = 6'b000001,
      START   = 6'b000010,
      WAIT    = 6'b000100,
      ACK     = 6'b001000,
      SHOW    = 6'b010000,
      FAULT   = 6'b100000
   } state_t;

   // Bit offset of entry k inside the flat row-major matrix bus.
   function automatic logic [IDX_W+1:0] nibble_lsb(input logic [IDX_W-1:0] k);
      return {k, 2'b00};
   endfunction

endpackage

// File: rtl/det_matrix_loader_timeout_counter.sv
// Watchdog for the WAIT state: counts enabled cycles and flags the cycle on
// which the count would reach TIMEOUT_CYCLES.
module det_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   // Saturates so a stalled enable can never wrap back into range.
   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         r_count <= '0;
      end else if (en && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = en && (r_count == CNT_LAST);

endmodule

// File: rtl/det_matrix_loader.sv
// Initiator for the det core Start/Ack handshake: packs 64 nibbles row-major,
// starts the core, captures the determinant and releases the core with Ack.
module det_matrix_loader
   import det_matrix_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    entry_valid,
   input  logic [ENTRY_W-1:0]      entry_data,
   output logic                    entry_ready,
   input  logic                    clear,
   input  logic                    result_ack,
   input  logic                    core_q_Enter,
   input  logic                    core_q_Done,
   input  logic signed [DET_W-1:0] core_det,
   output logic                    Start,
   output logic                    Ack,
   output logic [FLAT_W-1:0]       input_arr_flat,
   output logic [LOAD_W-1:0]       load_count,
   output logic signed [DET_W-1:0] result,
   output logic                    result_valid,
   output logic                    timeout_err,
   output logic                    busy
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [FLAT_W-1:0]       r_flat;
   logic [LOAD_W-1:0]       r_load_count;
   logic signed [DET_W-1:0] r_result;
   logic                    r_result_valid;
   logic                    r_timeout_err;
   logic                    w_transfer;
   logic                    w_expired;

   assign w_transfer = (r_state == START) && core_q_Enter;

   det_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .Clk    (Clk),
      .Reset  (Reset),
      .en     (r_state == WAIT),
      .clr    (w_transfer),
      .expired(w_expired)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         COLLECT: if (!clear && entry_valid && (r_load_count == LAST_IDX)) w_next_state = START;
         START:   if (core_q_Enter) w_next_state = WAIT;
         WAIT: begin
            // A same-cycle Done wins over the watchdog.
            if (core_q_Done)    w_next_state = ACK;
            else if (w_expired) w_next_state = FAULT;
         end
         ACK:     if (!core_q_Done) w_next_state = SHOW;
         SHOW:    if (result_ack) w_next_state = COLLECT;
         FAULT:   w_next_state = FAULT;
         default: w_next_state = COLLECT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_flat         <= '0;
         r_load_count   <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (clear) begin
                  r_flat       <= '0;
                  r_load_count <= '0;
               end else if (entry_valid) begin
                  r_flat[nibble_lsb(r_load_count[IDX_W-1:0]) +: ENTRY_W] <= entry_data;
                  r_load_count <= r_load_count + 1'b1;
               end
            end
            WAIT: begin
               if (core_q_Done)    r_result      <= core_det;
               else if (w_expired) r_timeout_err <= 1'b1;
            end
            ACK: begin
               if (!core_q_Done) r_result_valid <= 1'b1;
            end
            SHOW: begin
               if (result_ack) begin
                  r_result_valid <= 1'b0;
                  r_load_count   <= '0;
                  r_flat         <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign entry_ready    = (r_state == COLLECT);
   assign Start          = (r_state == START);
   assign Ack            = (r_state == ACK);
   assign busy           = (r_state == START) || (r_state == WAIT) || (r_state == ACK);
   assign input_arr_flat = r_flat;
   assign load_count     = r_load_count;
   assign result         = r_result;
   assign result_valid   = r_result_valid;
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed bench for det_matrix_loader; the bench itself plays the det core
// and checks every outcome against hand-derived values.
module tb_det_matrix_loader;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         entry_valid;
   logic [3:0]   entry_data;
   logic         entry_ready;
   logic         clear;
   logic         result_ack;
   logic         core_q_Enter;
   logic         core_q_Done;
   logic [31:0]  core_det;
   logic         Start;
   logic         Ack;
   logic [255:0] input_arr_flat;
   logic [6:0]   load_count;
   logic [31:0]  result;
   logic         result_valid;
   logic         timeout_err;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   det_matrix_loader #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .entry_valid   (entry_valid),
      .entry_data    (entry_data),
      .entry_ready   (entry_ready),
      .clear         (clear),
      .result_ack    (result_ack),
      .core_q_Enter  (core_q_Enter),
      .core_q_Done   (core_q_Done),
      .core_det      (core_det),
      .Start         (Start),
      .Ack           (Ack),
      .input_arr_flat(input_arr_flat),
      .load_count    (load_count),
      .result        (result),
      .result_valid  (result_valid),
      .timeout_err   (timeout_err),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_entries(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         entry_valid = 1'b1;
         entry_data  = 4'((k + base) % 16);
         tick();
      end
      entry_valid = 1'b0;
      entry_data  = 4'h0;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   logic [255:0] exp_flat;
   int           cyc;

   initial begin
      Reset = 1'b1; entry_valid = 1'b0; entry_data = 4'h0; clear = 1'b0;
      result_ack = 1'b0; core_q_Enter = 1'b0; core_q_Done = 1'b0; core_det = 32'h0;
      tick(); tick();

      check("rst_start",     256'(Start), 256'(0));
      check("rst_ack",       256'(Ack), 256'(0));
      check("rst_flat",      input_arr_flat, 256'(0));
      check("rst_count",     256'(load_count), 256'(0));
      check("rst_result",    256'(result), 256'(0));
      check("rst_rvalid",    256'(result_valid), 256'(0));
      check("rst_timeout",   256'(timeout_err), 256'(0));
      check("rst_ready",     256'(entry_ready), 256'(1));
      check("rst_busy",      256'(busy), 256'(0));
      Reset = 1'b0;
      tick();

      // Partial load, then clear colliding with an entry.
      load_entries(10, 1);
      exp_flat = '0;
      for (int k = 0; k < 10; k++) exp_flat[k*4 +: 4] = 4'(k + 1);
      check("part_count", 256'(load_count), 256'(10));
      check("part_flat",  input_arr_flat, exp_flat);
      clear = 1'b1; entry_valid = 1'b1; entry_data = 4'h7;
      tick();
      clear = 1'b0; entry_valid = 1'b0;
      check("clr_count", 256'(load_count), 256'(0));
      check("clr_flat",  input_arr_flat, 256'(0));
      check("clr_ready", 256'(entry_ready), 256'(1));

      // Full load of k%16.
      load_entries(63, 0);
      check("pre_last_start", 256'(Start), 256'(0));
      check("pre_last_ready", 256'(entry_ready), 256'(1));
      load_entries(1, 63);
      exp_flat = {4{64'hFEDC_BA98_7654_3210}};
      check("full_count",  256'(load_count), 256'(64));
      check("full_lo",     256'(input_arr_flat[3:0]), 256'(0));
      check("full_hi",     256'(input_arr_flat[255:252]), 256'(15));
      check("full_flat",   input_arr_flat, exp_flat);
      check("full_start",  256'(Start), 256'(1));
      check("full_ready",  256'(entry_ready), 256'(0));
      check("full_busy",   256'(busy), 256'(1));

      // Core withholds q_Enter for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("start_held", 256'(Start), 256'(1));
      end
      check("start_flat_stable", input_arr_flat, exp_flat);
      core_q_Enter = 1'b1;
      tick();
      core_q_Enter = 1'b0;
      check("wait_start", 256'(Start), 256'(0));
      check("wait_busy",  256'(busy), 256'(1));

      // Core finishes with det = -5 and holds q_Done for 3 Ack cycles.
      tick(); tick(); tick();
      check("wait_no_ack", 256'(Ack), 256'(0));
      core_det = 32'hFFFF_FFFB; core_q_Done = 1'b1;
      tick();
      core_det = 32'h1234_5678;
      check("ack1",        256'(Ack), 256'(1));
      check("ack_result",  256'(result), 256'(32'hFFFF_FFFB));
      check("ack_rvalid",  256'(result_valid), 256'(0));
      tick();
      check("ack2", 256'(Ack), 256'(1));
      tick();
      check("ack3", 256'(Ack), 256'(1));
      core_q_Done = 1'b0;
      tick();
      check("show_ack",    256'(Ack), 256'(0));
      check("show_rvalid", 256'(result_valid), 256'(1));
      check("show_signed", 256'($signed(result) == -5), 256'(1));
      check("show_busy",   256'(busy), 256'(0));
      entry_valid = 1'b1; clear = 1'b1;
      tick();
      entry_valid = 1'b0; clear = 1'b0;
      check("show_ign_count", 256'(load_count), 256'(64));
      check("show_ign_flat",  input_arr_flat, exp_flat);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check("rack_rvalid", 256'(result_valid), 256'(0));
      check("rack_count",  256'(load_count), 256'(0));
      check("rack_flat",   input_arr_flat, 256'(0));
      check("rack_ready",  256'(entry_ready), 256'(1));
      check("rack_result", 256'(result), 256'(32'hFFFF_FFFB));

      // Reset in the middle of WAIT.
      load_entries(64, 5);
      core_q_Enter = 1'b1;
      tick();
      core_q_Enter = 1'b0;
      tick(); tick(); tick();
      check("mid_wait_busy", 256'(busy), 256'(1));
      pulse_reset();
      check("mrst_start",   256'(Start), 256'(0));
      check("mrst_ack",     256'(Ack), 256'(0));
      check("mrst_flat",    input_arr_flat, 256'(0));
      check("mrst_count",   256'(load_count), 256'(0));
      check("mrst_result",  256'(result), 256'(0));
      check("mrst_rvalid",  256'(result_valid), 256'(0));
      check("mrst_timeout", 256'(timeout_err), 256'(0));
      check("mrst_ready",   256'(entry_ready), 256'(1));
      check("mrst_busy",    256'(busy), 256'(0));

      // Watchdog: q_Done never arrives.
      load_entries(64, 3);
      core_q_Enter = 1'b1;
      tick();
      core_q_Enter = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (timeout_err) begin
            cyc = i;
            break;
         end
      end
      check("timeout_cycles", 256'(cyc), 256'(16));
      core_q_Done = 1'b1; result_ack = 1'b1; entry_valid = 1'b1; core_q_Enter = 1'b1;
      tick(); tick(); tick();
      check("fault_timeout", 256'(timeout_err), 256'(1));
      check("fault_start",   256'(Start), 256'(0));
      check("fault_ack",     256'(Ack), 256'(0));
      check("fault_ready",   256'(entry_ready), 256'(0));
      check("fault_busy",    256'(busy), 256'(0));
      check("fault_result",  256'(result), 256'(0));
      core_q_Done = 1'b0; result_ack = 1'b0; entry_valid = 1'b0; core_q_Enter = 1'b0;
      pulse_reset();
      check("frst_timeout", 256'(timeout_err), 256'(0));
      check("frst_ready",   256'(entry_ready), 256'(1));
      check("frst_count",   256'(load_count), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
